// File: rtl/alu32_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu32_issue_ctrl                                                |
// | Purpose  : Issue/sequencing stage ahead of the ALU32 gated logic units.    |
// |            Accepts an operand pair and opcode, holds the operands on the   |
// |            unit inputs, enables one unit for EXEC_CYCLES settle cycles,    |
// |            captures the OR-combined unit result and presents it           |
// |            downstream over a valid/ready handshake.                        |
// | Options  : ALU_ISSUE_ZFLAG_EN - build the registered result-is-zero flag.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu32_issue_ctrl #(
  parameter int NUM_UNITS   = 5,
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [31:0]          InA,
  input  logic [31:0]          InB,
  input  logic [2:0]           InOp,
  output logic [31:0]          OpA,
  output logic [31:0]          OpB,
  output logic [NUM_UNITS-1:0] UnitEn,
  input  logic [31:0]          UnitResult,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [31:0]          OutData,
  output logic                 OutErr,
  output logic                 OutZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]     c_cnt_init = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [NUM_UNITS-1:0] c_one      = NUM_UNITS'(1);
  localparam logic [3:0]           c_num_op   = 4'(NUM_UNITS);

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [31:0]            r_op_a;
  logic [31:0]            r_op_b;
  logic [NUM_UNITS-1:0]   r_unit_en;
  logic [31:0]            r_out_data;
  logic                   r_out_err;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_legal;
  logic [NUM_UNITS-1:0]   w_onehot;
  logic                   w_capture;

  // Opcode legality and the one-hot enable pattern it selects
  always_comb begin
    w_legal   = ({1'b0, InOp} < c_num_op);
    w_onehot  = c_one << InOp;
    w_capture = (r_state == S_EXEC) && (r_cnt == '0);
  end

  // Main sequencer: every output is a register so UnitEn cannot glitch
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_unit_en   <= '0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InValid) begin
            r_op_a     <= InA;
            r_op_b     <= InB;
            r_in_ready <= 1'b0;
            if (w_legal) begin
              r_state   <= S_EXEC;
              r_cnt     <= c_cnt_init;
              r_unit_en <= w_onehot;
            end else begin
              // Illegal opcode skips execution entirely; no unit is enabled
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
              r_out_err   <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_out_data  <= UnitResult;
            r_out_err   <= 1'b0;
            r_unit_en   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (OutReady) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_unit_en   <= '0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_ZFLAG_EN
  logic r_out_zero;

  // Zero flag captured alongside OutData; illegal opcodes report a zero result
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_out_zero <= 1'b0;
    end else if ((r_state == S_IDLE) && InValid && !w_legal) begin
      r_out_zero <= 1'b1;
    end else if (w_capture) begin
      r_out_zero <= (UnitResult == 32'h0);
    end
  end

  assign OutZero = r_out_zero;
`else
  assign OutZero = 1'b0;
`endif

  assign InReady  = r_in_ready;
  assign OutValid = r_out_valid;
  assign OpA      = r_op_a;
  assign OpB      = r_op_b;
  assign UnitEn   = r_unit_en;
  assign OutData  = r_out_data;
  assign OutErr   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_alu32_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu32_issue_ctrl                                             |
// | Purpose  : Self-checking bench for alu32_issue_ctrl. Two instances         |
// |            (EXEC_CYCLES = 1 and 3) share clock and reset; each has its own |
// |            behavioural gated-unit bank. Expected results come from a plain |
// |            opcode->function reference model.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu32_issue_ctrl;

  localparam int EX0 = 1;
  localparam int EX1 = 3;

  logic        clk;
  logic        rst;
  logic        in_valid    [2];
  logic        in_ready    [2];
  logic [31:0] in_a        [2];
  logic [31:0] in_b        [2];
  logic [2:0]  in_op       [2];
  logic [31:0] op_a        [2];
  logic [31:0] op_b        [2];
  logic [4:0]  unit_en     [2];
  logic [31:0] unit_result [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [31:0] out_data    [2];
  logic        out_err     [2];
  logic        out_zero    [2];

  int n_checks = 0;
  int n_fail   = 0;

  alu32_issue_ctrl #(.NUM_UNITS(5), .EXEC_CYCLES(EX0), .CNT_W(4)) u_dut0 (
    .Clk(clk), .Rst(rst),
    .InValid(in_valid[0]), .InReady(in_ready[0]),
    .InA(in_a[0]), .InB(in_b[0]), .InOp(in_op[0]),
    .OpA(op_a[0]), .OpB(op_b[0]), .UnitEn(unit_en[0]),
    .UnitResult(unit_result[0]),
    .OutValid(out_valid[0]), .OutReady(out_ready[0]),
    .OutData(out_data[0]), .OutErr(out_err[0]), .OutZero(out_zero[0])
  );

  alu32_issue_ctrl #(.NUM_UNITS(5), .EXEC_CYCLES(EX1), .CNT_W(4)) u_dut1 (
    .Clk(clk), .Rst(rst),
    .InValid(in_valid[1]), .InReady(in_ready[1]),
    .InA(in_a[1]), .InB(in_b[1]), .InOp(in_op[1]),
    .OpA(op_a[1]), .OpB(op_b[1]), .UnitEn(unit_en[1]),
    .UnitResult(unit_result[1]),
    .OutValid(out_valid[1]), .OutReady(out_ready[1]),
    .OutData(out_data[1]), .OutErr(out_err[1]), .OutZero(out_zero[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gated unit bank: each unit outputs 0 unless its Enable is high
  function automatic logic [31:0] unit_bank(input logic [4:0] en, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    if (en[0]) r = r | (a & b);
    if (en[1]) r = r | (a | b);
    if (en[2]) r = r | (a ^ b);
    if (en[3]) r = r | ~(a | b);
    if (en[4]) r = r | ~(a & b);
    return r;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) unit_result[d] = unit_bank(unit_en[d], op_a[d], op_b[d]);
  end

  // Reference model: what the stage must report for a request
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_zero(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_ISSUE_ZFLAG_EN
    return (op > 3'd4) ? 1'b1 : (ref_result(op, a, b) == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exec_of(input int d);
    return (d == 0) ? EX0 : EX1;
  endfunction

  // Present a request at a negedge; returns just after the accepting edge
  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    n_checks++; if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL issue_ready d=%0d got %b exp 1", d, in_ready[d]); end
    in_valid[d] = 1'b1; in_op[d] = op; in_a[d] = a; in_b[d] = b;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_a[d] = $urandom; in_b[d] = $urandom; in_op[d] = 3'($urandom);
  endtask

  // Follow an accepted request through execution, result hold and handshake
  task automatic check_rest(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int stall, input bit queued);
    logic [4:0]  exp_en;
    logic [31:0] exp_data;
    int          n_en;
    exp_en   = (op < 3'd5) ? (5'd1 << op) : 5'd0;
    n_en     = (op < 3'd5) ? exec_of(d) : 0;
    exp_data = ref_result(op, a, b);
    out_ready[d] = 1'b0;
    for (int k = 0; k < n_en; k++) begin
      @(negedge clk);
      n_checks++; if (unit_en[d] !== exp_en) begin n_fail++; $display("FAIL exec_unit_en d=%0d cyc=%0d got %b exp %b", d, k, unit_en[d], exp_en); end
      n_checks++; if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0) begin n_fail++; $display("FAIL exec_handshake d=%0d cyc=%0d got v=%b r=%b exp 0 0", d, k, out_valid[d], in_ready[d]); end
      n_checks++; if (op_a[d] !== a || op_b[d] !== b) begin n_fail++; $display("FAIL exec_operands d=%0d got %h %h exp %h %h", d, op_a[d], op_b[d], a, b); end
      if (k == 0 && n_en > 1) begin in_a[d] = ~in_a[d]; in_b[d] = ~in_b[d]; end
    end
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      n_checks++; if (out_valid[d] !== 1'b1) begin n_fail++; $display("FAIL done_valid d=%0d s=%0d got %b exp 1", d, s, out_valid[d]); end
      n_checks++; if (out_data[d] !== exp_data) begin n_fail++; $display("FAIL done_data d=%0d op=%0d s=%0d got %h exp %h", d, op, s, out_data[d], exp_data); end
      n_checks++; if (out_err[d] !== (op > 3'd4)) begin n_fail++; $display("FAIL done_err d=%0d op=%0d got %b exp %b", d, op, out_err[d], (op > 3'd4)); end
      n_checks++; if (out_zero[d] !== ref_zero(op, a, b)) begin n_fail++; $display("FAIL done_zero d=%0d op=%0d got %b exp %b", d, op, out_zero[d], ref_zero(op, a, b)); end
      n_checks++; if (unit_en[d] !== 5'd0 || in_ready[d] !== 1'b0) begin n_fail++; $display("FAIL done_idle_units d=%0d s=%0d got en=%b r=%b exp 0 0", d, s, unit_en[d], in_ready[d]); end
      if (s < stall) @(negedge clk);
    end
    if (queued == 1'b0) in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    n_checks++; if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL release d=%0d got v=%b r=%b exp 0 1", d, out_valid[d], in_ready[d]); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; in_op[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready d=%0d got %b exp 1", d, in_ready[d]); end
      n_checks++; if (unit_en[d] !== 5'd0) begin n_fail++; $display("FAIL reset_unit_en d=%0d got %b exp 0", d, unit_en[d]); end
      n_checks++; if (out_valid[d] !== 1'b0 || out_err[d] !== 1'b0 || out_zero[d] !== 1'b0) begin n_fail++; $display("FAIL reset_flags d=%0d got v=%b e=%b z=%b exp 0", d, out_valid[d], out_err[d], out_zero[d]); end
      n_checks++; if (out_data[d] !== 32'h0 || op_a[d] !== 32'h0 || op_b[d] !== 32'h0) begin n_fail++; $display("FAIL reset_data d=%0d got %h %h %h exp 0", d, out_data[d], op_a[d], op_b[d]); end
    end
  endtask

  task automatic test_or_single();
    issue(0, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F);
    check_rest(0, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 0, 1'b0);
  endtask

  task automatic test_and_exec3();
    issue(1, 3'd0, 32'hFFFF_0000, 32'h00FF_FF00);
    check_rest(1, 3'd0, 32'hFFFF_0000, 32'h00FF_FF00, 2, 1'b0);
  endtask

  task automatic test_illegal();
    issue(0, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    check_rest(0, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0);
    issue(1, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_rest(1, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] c, e;
    c = $urandom; e = $urandom;
    issue(1, 3'd2, 32'hDEAD_BEEF, 32'h0F0F_F0F0);
    // Next request waits on the input for the whole execution and stall
    in_valid[1] = 1'b1; in_op[1] = 3'd4; in_a[1] = c; in_b[1] = e;
    check_rest(1, 3'd2, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 10, 1'b1);
    in_a[1] = c; in_b[1] = e;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    check_rest(1, 3'd4, c, e, 0, 1'b0);
  endtask

  task automatic test_zero_flag();
    issue(0, 3'd0, 32'hAAAA_AAAA, 32'h5555_5555);
    check_rest(0, 3'd0, 32'hAAAA_AAAA, 32'h5555_5555, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    issue(1, 3'd3, 32'h0000_FFFF, 32'h00FF_00FF);
    @(negedge clk);
    n_checks++; if (unit_en[1] !== 5'b01000) begin n_fail++; $display("FAIL arst_pre_en got %b exp 01000", unit_en[1]); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (unit_en[1] !== 5'd0) begin n_fail++; $display("FAIL arst_unit_en got %b exp 0", unit_en[1]); end
    n_checks++; if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL arst_state got r=%b v=%b exp 1 0", in_ready[1], out_valid[1]); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid[1] !== 1'b0 || unit_en[1] !== 5'd0 || in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL arst_after k=%0d got v=%b en=%b r=%b exp 0 0 1", k, out_valid[1], unit_en[1], in_ready[1]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int          d;
      logic [2:0]  op;
      logic [31:0] a, b;
      d  = int'($urandom_range(0, 1));
      op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? ~a : $urandom;
      issue(d, op, a, b);
      check_rest(d, op, a, b, int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_or_single();
    test_and_exec3();
    test_illegal();
    test_back_to_back();
    test_zero_flag();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
